// File: rtl/result_uart_tx_if.sv
// Result strobe bundle from the hashing core to the UART result transmitter.
interface result_uart_tx_if;
    logic        new_result;
    logic [31:0] result_data;
    logic        hashing;

    modport master (output new_result, result_data, hashing);
    modport slave  (input  new_result, result_data, hashing);
endinterface

// File: rtl/result_uart_tx.sv
// Queues miner results in a small FIFO and sends each one as a framed 8N1 UART packet.
// Optional macro RESULT_TX_CHECKSUM_EN appends an XOR checksum byte to every frame.
module result_uart_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    result_uart_tx_if.slave        res,
    output logic                   txd,
    output logic                   busy,
    output logic [FIFO_AW:0]       fifo_count,
    output logic                   overflow
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int BW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 5;
`endif
    localparam int FW = NBYTES * 8;

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

    logic [32:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               full, push_ok, pop;

    state_t             state_q, state_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [2:0]         byte_q, byte_d;
    logic [FW-1:0]      frame_q, frame_d;
    logic               txd_q, txd_d;

    logic [32:0]        head;
    logic [7:0]         tag;
    logic [FW-1:0]      frame_load;
    logic [7:0]         cur_byte;
    logic               baud_tc;

    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        push_ok    = res.new_result && (!full || pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push_ok) - CW'(pop);
        overflow_d = overflow_q | (res.new_result & full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {~res.hashing, res.result_data};
        end
    end

    always_comb begin
        head = mem_q[rd_ptr_q];
        tag  = {overflow_q, 5'b00000, head[32], ~head[32]};
`ifdef RESULT_TX_CHECKSUM_EN
        frame_load = {tag, head[31:0],
                      tag ^ head[31:24] ^ head[23:16] ^ head[15:8] ^ head[7:0]};
`else
        frame_load = {tag, head[31:0]};
`endif
        cur_byte = frame_q[FW-1 -: 8];
        baud_tc  = (baud_q == BW'(DIV - 1));
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        pop     = 1'b0;
        txd_d   = 1'b1;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    frame_d = frame_load;
                    byte_d  = 3'd0;
                    bit_d   = 3'd0;
                    state_d = START;
                end
            end
            START: begin
                txd_d  = 1'b0;
                baud_d = baud_tc ? '0 : baud_q + BW'(1);
                if (baud_tc) state_d = DATA;
            end
            DATA: begin
                txd_d  = cur_byte[bit_q];
                baud_d = baud_tc ? '0 : baud_q + BW'(1);
                if (baud_tc) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                baud_d = baud_tc ? '0 : baud_q + BW'(1);
                if (baud_tc) begin
                    if (byte_q == 3'(NBYTES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        frame_d = {frame_q[FW-9:0], 8'h00};
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // txd is registered from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            frame_q    <= '0;
            txd_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            frame_q    <= frame_d;
            txd_q      <= txd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign txd        = txd_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: UART receiver monitor against a byte scoreboard.
module tb_result_uart_tx;
    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int DIV      = 10;
    localparam int AW       = 3;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    typedef struct {
        logic        hashing;
        logic [31:0] data;
        logic [7:0]  exp_tag;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        txd, busy, overflow;
    logic [AW:0] fifo_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  sb_q[$];
    bit          ignore_rx = 1'b0;

    result_uart_tx_if res_if ();

    result_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res        (res_if),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void expect_frame(input logic [7:0] tag, input logic [31:0] d);
        logic [7:0] x;
        sb_q.push_back(tag);
        sb_q.push_back(d[31:24]);
        sb_q.push_back(d[23:16]);
        sb_q.push_back(d[15:8]);
        sb_q.push_back(d[7:0]);
        x = tag ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
        if (NB == 6) sb_q.push_back(x);
    endfunction

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // UART receiver: sample mid-bit, compare each byte against the scoreboard head.
    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge txd);
            repeat (DIV / 2) @(posedge clk);
            #1;
            if (!ignore_rx) check("start_bit", 32'(txd), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(posedge clk);
                #1;
                b[i] = txd;
            end
            repeat (DIV) @(posedge clk);
            #1;
            if (!ignore_rx) begin
                check("stop_bit", 32'(txd), 32'd1);
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_byte: got 0x%0h, expected no byte at %0t", b, $time);
                end else begin
                    check("rx_byte", 32'(b), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin : main
        vec_t        tbl[4];
        int          k;
        int          peak;
        int          stray;
        logic [31:0] d;
        logic        h;
        logic [7:0]  t;

        tbl[0] = '{1'b1, 32'h12345678, 8'h01};
        tbl[1] = '{1'b0, 32'hFFFFFFFF, 8'h02};
        tbl[2] = '{1'b1, 32'h00000000, 8'h01};
        tbl[3] = '{1'b0, 32'hA5C30F81, 8'h02};

        res_if.new_result  = 1'b0;
        res_if.result_data = '0;
        res_if.hashing     = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Data and hashing wiggling without a strobe must not enqueue anything.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            res_if.result_data = $urandom;
            res_if.hashing     = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("no_strobe_count", 32'(fifo_count), 32'd0);
        check("no_strobe_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            res_if.new_result  = 1'b1;
            res_if.result_data = tbl[i].data;
            res_if.hashing     = tbl[i].hashing;
            expect_frame(tbl[i].exp_tag, tbl[i].data);
            @(negedge clk);
            res_if.new_result = 1'b0;
            check("push_count", 32'(fifo_count), 32'd1);
            check("push_busy", 32'(busy), 32'd1);
            @(negedge clk);
            check("pop_count", 32'(fifo_count), 32'd0);
            check("pre_start_txd", 32'(txd), 32'd1);
            @(negedge clk);
            check("start_latency_txd", 32'(txd), 32'd0);
            k = 2;
            while (busy && k < 2000) begin
                @(negedge clk);
                k++;
            end
            check("frame_cycles", 32'(k), 32'(1 + NB * 10 * DIV));
            check("frame_bytes_left", 32'(sb_q.size()), 32'd0);
        end

        // Nine back-to-back pushes: first pops at once, eight fill the FIFO.
        peak = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i > 0 && int'(fifo_count) > peak) peak = int'(fifo_count);
            d = 32'h10203040 + 32'(i) * 32'h01010101;
            h = 1'(i % 2);
            res_if.new_result  = 1'b1;
            res_if.result_data = d;
            res_if.hashing     = h;
            expect_frame(h ? 8'h01 : 8'h02, d);
        end
        @(negedge clk);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        res_if.new_result = 1'b0;
        check("burst9_peak", 32'(peak), 32'd8);
        check("burst9_overflow", 32'(overflow), 32'd0);
        wait_idle(6000, "burst9_idle");
        check("burst9_bytes_left", 32'(sb_q.size()), 32'd0);
        check("burst9_overflow_end", 32'(overflow), 32'd0);

        // Ten pushes: the tenth is dropped, later frames carry the overflow flag.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            d = 32'hC0DE0000 + 32'(i);
            h = 1'(i % 3 != 0);
            res_if.new_result  = 1'b1;
            res_if.result_data = d;
            res_if.hashing     = h;
            t = h ? 8'h01 : 8'h02;
            if (i == 0) expect_frame(t, d);
            else if (i < 9) expect_frame(t | 8'h80, d);
        end
        @(negedge clk);
        res_if.new_result = 1'b0;
        check("burst10_count", 32'(fifo_count), 32'd8);
        check("burst10_overflow", 32'(overflow), 32'd1);
        wait_idle(6000, "burst10_idle");
        check("burst10_bytes_left", 32'(sb_q.size()), 32'd0);
        check("burst10_overflow_sticky", 32'(overflow), 32'd1);

        // Asynchronous reset mid-frame with entries queued.
        ignore_rx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            res_if.new_result  = 1'b1;
            res_if.result_data = 32'h55AA0000 + 32'(i);
            res_if.hashing     = 1'b1;
        end
        @(negedge clk);
        res_if.new_result = 1'b0;
        check("pre_reset_count", 32'(fifo_count), 32'd3);
        repeat (40) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_txd", 32'(txd), 32'd1);
        check("async_rst_count", 32'(fifo_count), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) stray++;
        end
        check("post_reset_quiet", 32'(stray), 32'd0);
        sb_q.delete();
        ignore_rx = 1'b0;

        // After reset the overflow flag is gone from the tag.
        @(negedge clk);
        res_if.new_result  = 1'b1;
        res_if.result_data = 32'hDEADBEEF;
        res_if.hashing     = 1'b1;
        expect_frame(8'h01, 32'hDEADBEEF);
        @(negedge clk);
        res_if.new_result = 1'b0;
        wait_idle(2000, "final_idle");
        check("final_bytes_left", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Consumer end of the miner's result interface.
- Captures every result pulse from the hashing core (found nonce or range-exhausted marker) into a small FIFO.
- Serialises each result to the host as a fixed-length framed UART packet (8N1, LSB first).
- Sits between the work handler's result outputs and the board TX pin; host-side software parses the frames.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; DIV = CLK_FREQ/BAUD (integer, truncated, must be >= 2)
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries of 33 bits {final, nonce}

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
new_result  input  1  one-cycle strobe; a result is present this cycle
result_data  input  32  nonce, valid when new_result=1
hashing  input  1  core still hashing; sampled with new_result, 0 means range exhausted
txd  output  1  UART serial out, idle high
busy  output  1  1 while a frame is being sent or the FIFO is non-empty
fifo_count  output  FIFO_AW+1  entries currently queued
overflow  output  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset (async, rst_n=0) forces:
  - txd=1, busy=0, fifo_count=0, overflow=0
  - FSM to IDLE, bit/baud counters to 0
  - FIFO pointers cleared; contents discarded, including a frame in flight
- On release, the first edge behaves as IDLE.
- Push:
  - On any edge with new_result=1, write {~hashing, result_data}.
  - fifo_count increments on the same edge.
  - If FIFO full and no pop on that edge: entry dropped, overflow<=1, count unchanged.
  - Simultaneous push+pop when full: push accepted, count unchanged.
- Frame: 5 bytes, in order:
  - tag: 0x01 = nonce found, 0x02 = range exhausted (final=1); bit7 set if overflow=1 at load time
  - result_data[31:24], [23:16], [15:8], [7:0]
- FSM states:
  - IDLE: txd=1. If FIFO non-empty, pop the head on this edge, latch tag and nonce into the shift buffer, go to START.
  - START: txd=0 for DIV cycles.
  - DATA: 8 bits LSB first, each held DIV cycles.
  - STOP: txd=1 for DIV cycles. If bytes remain in the frame, go to START with the next byte; else go to IDLE.
- Timing and latency:
  - Push on edge N with FIFO empty and FSM idle: pop at edge N+1; txd falls after edge N+2.
  - Each byte takes exactly 10*DIV cycles; a frame takes exactly 50*DIV cycles.
  - Back-to-back frames are separated by exactly one IDLE cycle.
- Baud counter:
  - Counts 0..DIV-1 and wraps to 0 at each bit boundary.
  - Bit index wraps 7->0 on the DATA->STOP transition.
- busy = (state != IDLE) | (fifo_count != 0).
- overflow clears only on reset.
- result_data and hashing are ignored when new_result=0.

Optional Feature:
- Macro: RESULT_TX_CHECKSUM_EN.
- When defined: a 6th byte is appended to each frame, the XOR of the 5 preceding bytes (tag included, overflow bit included). Frame time becomes 60*DIV cycles.
- When undefined: 5-byte frames, no checksum logic present.

Test Plan:
- CLK_FREQ=1000000, BAUD=100000 (DIV=10); pulse new_result with result_data=0x12345678, hashing=1 -> txd sends 0x01,0x12,0x34,0x56,0x78 over 500 cycles; start bit begins 2 cycles after the push; busy falls after the stop bit.
- Same setup, new_result with hashing=0, data=0xFFFFFFFF -> tag 0x02 followed by four 0xFF bytes.
- Push 9 results on consecutive cycles with FIFO_AW=3 -> first pops immediately, all 9 transmitted in order; overflow stays 0; fifo_count peaks at 8.
- Push 10 results back-to-back -> 10th dropped, overflow=1; the next frame loaded carries tag 0x81; 9 frames total.
- Assert rst_n=0 mid-DATA of frame 1 with 3 entries queued -> txd=1, fifo_count=0, busy=0 immediately (async); no further bytes after release.
- With RESULT_TX_CHECKSUM_EN, data=0x12345678, found -> 6th byte = 0x01^0x12^0x34^0x56^0x78 = 0x09; frame lasts 600 cycles.
